// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: state encoding of the arbiter FSM and the owner encodings, which
// double as the IorD address-mux select values driven on sel.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Owner encodings; these are also the values driven on sel.
  localparam logic OWNER_IF   = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Width of the latency down-counter (MEM_LATENCY up to 15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the shared fetch/data memory port
//
// Purpose: shares one memory port between instruction fetch and load/store.
// A winning request is latched in IDLE, strobed to memory in ACCESS, and
// completed after MEM_LATENCY cycles with an rvalid pulse to its owner.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   if_req/if_addr         fetch request and address
//   if_gnt/if_rvalid       fetch grant and completion pulses
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_gnt/d_rvalid         data grant and completion pulses
//   rdata                  read return (follows mem_rdata)
//   mem_addr/mem_wdata     registered memory address and store data
//   mem_re/mem_we          one-cycle read/write strobes
//   mem_rdata              memory read data
//   sel                    IorD select: 0 = fetch, 1 = data; holds current owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDR_LENGTH-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ADDR_LENGTH-1:0] d_addr,
  input  logic [DATA_LENGTH-1:0] d_wdata,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [DATA_LENGTH-1:0] rdata,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  output logic                   mem_re,
  output logic                   mem_we,
  input  logic [DATA_LENGTH-1:0] mem_rdata,
  output logic                   sel
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  state_t                 r_state;
  logic                   r_last_served;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_if_gnt;
  logic                   r_d_gnt;
  logic                   r_if_rvalid;
  logic                   r_d_rvalid;
  logic                   r_mem_re;
  logic                   r_mem_we;
  logic                   r_sel;
  logic [ADDR_LENGTH-1:0] r_mem_addr;
  logic [DATA_LENGTH-1:0] r_mem_wdata;

  logic w_any_req;
  logic w_pick_data;

  // Data wins when it is the only requester, or on a tie when fetch was
  // served last.
  assign w_any_req   = if_req | d_req;
  assign w_pick_data = d_req & (~if_req | (r_last_served == OWNER_IF));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last_served <= OWNER_DATA;
      r_cnt         <= '0;
      r_if_gnt      <= 1'b0;
      r_d_gnt       <= 1'b0;
      r_if_rvalid   <= 1'b0;
      r_d_rvalid    <= 1'b0;
      r_mem_re      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_sel         <= OWNER_IF;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_sel         <= w_pick_data;
            r_last_served <= w_pick_data;
            r_state       <= ACCESS;
            if (w_pick_data) begin
              r_mem_addr <= d_addr;
              r_d_gnt    <= 1'b1;
              if (d_we) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= d_wdata;
              end else begin
                r_mem_re <= 1'b1;
              end
            end else begin
              r_mem_addr <= if_addr;
              r_if_gnt   <= 1'b1;
              r_mem_re   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          r_cnt   <= LAT_M1;
          r_state <= WAIT;
          // rvalid is registered, so it is raised on the edge that makes
          // cnt reach zero; with latency 1 that is this edge.
          if (LAT_M1 == '0) begin
            r_if_rvalid <= (r_sel == OWNER_IF);
            r_d_rvalid  <= (r_sel == OWNER_DATA);
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_if_rvalid <= (r_sel == OWNER_IF);
              r_d_rvalid  <= (r_sel == OWNER_DATA);
            end
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign sel       = r_sel;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-channel arbiter that shares the single unified memory port of the multi-cycle MIPS core between the instruction-fetch requester and the load/store requester. It registers the winning request, drives the memory address/data/strobe lines and the IorD address-mux select, counts a fixed memory latency, and returns a completion pulse to the owner. Arbitration is round-robin on contention, so neither channel starves.

## Interface
- DATA_LENGTH, 32, width of data words
- ADDR_LENGTH, 32, width of addresses
- MEM_LATENCY, 1, cycles from the mem_re/mem_we cycle to mem_rdata valid; legal range 1..15

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_LENGTH  fetch address; stable while if_req is high
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rvalid  out  1  one-cycle completion pulse; rdata valid
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_LENGTH  data address
- d_wdata  in  DATA_LENGTH  store data
- d_gnt  out  1  one-cycle grant pulse to data
- d_rvalid  out  1  one-cycle completion pulse, for loads and stores
- rdata  out  DATA_LENGTH  read return; equals mem_rdata
- mem_addr  out  ADDR_LENGTH  registered memory address
- mem_wdata  out  DATA_LENGTH  registered store data
- mem_re  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_rdata  in  DATA_LENGTH  memory read data
- sel  out  1  address-mux select (IorD): 0 = fetch, 1 = data; holds the current owner

## Operation
- States: IDLE, ACCESS, WAIT.
- **IDLE**
  - No request: stay in IDLE.
  - One request: that requester wins.
  - Both requesting: the requester that was not served last wins.
  - On a win, at the clock edge: latch owner into sel, update last_served, and go to ACCESS.
  - On a win, also latch mem_addr from the winner's address; for a data store, latch mem_wdata from d_wdata.
- **ACCESS** (one cycle)
  - Assert the owner's gnt.
  - Assert mem_re for a fetch or a load; assert mem_we for a store.
  - Load cnt = MEM_LATENCY-1, then go to WAIT.
- **WAIT**
  - cnt != 0: decrement.
  - cnt == 0: assert the owner's rvalid, drive rdata = mem_rdata, and go to IDLE at the next edge.
  - Stores also produce d_rvalid; rdata is don't-care for stores.
- Requests arriving in ACCESS or WAIT are not granted. They must stay asserted and are evaluated in IDLE.
- After gnt, a requester may drop req or change its address/data. The latched values are unaffected.
- cnt width: 4 bits.
- mem_addr, mem_wdata and sel hold their values until the next grant.
- if_rvalid and d_rvalid are never both high. if_gnt and d_gnt are never both high.

## Timing
- Every output resets to 0: gnts, rvalids, mem_re, mem_we, mem_addr, mem_wdata, sel.
- Reset state: state = IDLE, last_served = DATA, so the first tie goes to fetch.
- Request seen in IDLE at cycle N:
  - gnt and the strobe in cycle N+1.
  - rvalid in cycle N+1+MEM_LATENCY.
  - IDLE again in cycle N+2+MEM_LATENCY.
- Back-to-back throughput: one transaction per MEM_LATENCY+2 cycles.
- Reset in ACCESS or WAIT aborts the transfer: no rvalid for it, all outputs at 0 in the next cycle, last_served = DATA.
- A req dropped before gnt is simply lost. This is a protocol violation and produces no error output.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT);
  - owner constants OWNER_IF = 1'b0 and OWNER_DATA = 1'b1, which are also the sel encodings.
- No sub-module. The round-robin pick is a two-input expression inline in the IDLE decode.

## Test plan
- **Reset:** rst high for 2 cycles mid-WAIT → all outputs 0 next cycle; no rvalid; the next tie goes to fetch.
- **Single fetch, MEM_LATENCY=2:** if_req with if_addr=0x0040_0000 at cycle 0 →
  - if_gnt, mem_re, sel=0 and mem_addr=0x0040_0000 at cycle 1;
  - if_rvalid at cycle 3 with rdata = mem_rdata = 0x2008_0005.
- **Contention:** if_req and d_req both held from reset, MEM_LATENCY=1 →
  - grants alternate IF, D, IF, D, with a grant every 3 cycles;
  - sel follows 0, 1, 0, 1.
- **Store:** d_req, d_we=1, d_addr=0x1001_0004, d_wdata=0xDEAD_BEEF →
  - mem_we pulse with those values and sel=1;
  - d_rvalid MEM_LATENCY cycles later; mem_re stays 0 throughout.
- **Late request:** d_req raised during a fetch WAIT → no d_gnt until IDLE; d_gnt in the cycle after IDLE; the fetch's if_rvalid is unaffected.
- **Latency sweep:** MEM_LATENCY = 1, 4, 15 → rvalid exactly MEM_LATENCY cycles after the strobe; never two rvalids per grant.
